// File: rtl/completion_arbiter_if.sv
// Completion-arbiter bus: per-unit result requests in, one registered result out.
interface completion_arbiter_if #(
  parameter int N = 7,
  parameter int W = 32
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic           flush_i;
  logic [N-1:0]   req_valid_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           out_valid_o;
  logic [W-1:0]   out_data_o;
  logic [N-1:0]   out_sel_o;
  logic [IW-1:0]  out_idx_o;
  logic           out_ready_i;

  modport master (
    output flush_i, req_valid_i, req_data_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_data_o, out_sel_o, out_idx_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_data_i, out_ready_i,
    output req_ready_o, out_valid_o, out_data_o, out_sel_o, out_idx_o
  );
endinterface

// File: rtl/completion_arbiter.sv
// Fixed-priority completion arbiter with age-based starvation promotion; 1-cycle registered result.
// Grants only when the result register is empty or draining this cycle; flush and reset block all grants.
module completion_arbiter #(
  parameter int N            = 7,
  parameter int W            = 32,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 reset,
  completion_arbiter_if.slave bus
);
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

  logic [AW-1:0] age_q [N];
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [N-1:0]  out_sel_q;
  logic [IW-1:0] out_idx_q;

  logic          load_ok;
  logic [N-1:0]  starved;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic [W-1:0]  grant_data;

  always_comb begin
    load_ok = (~out_valid_q | bus.out_ready_i) & ~bus.flush_i & ~reset;
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < N; i++) begin
      starved[i] = bus.req_valid_i[i] && (age_q[i] == AGE_MAX);
    end
  end

  // Scan from the lowest priority upward so the last hit is the lowest index.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    if (load_ok) begin
      for (int i = N - 1; i >= 0; i--) begin
        if ((|starved) ? starved[i] : bus.req_valid_i[i]) begin
          grant      = '0;
          grant[i]   = 1'b1;
          grant_idx  = IW'(i);
          grant_data = bus.req_data_i[i*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_idx_q   <= '0;
      for (int i = 0; i < N; i++) begin
        age_q[i] <= '0;
      end
    end else if (bus.flush_i) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      for (int i = 0; i < N; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      if (|grant) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_sel_q   <= grant;
        out_idx_q   <= grant_idx;
      end else if (out_valid_q && bus.out_ready_i) begin
        out_valid_q <= 1'b0;
        out_sel_q   <= '0;
      end
      // Ages keep counting through downstream stalls, saturating at the limit.
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid_i[i] || grant[i]) begin
          age_q[i] <= '0;
        end else if (age_q[i] < AGE_MAX) begin
          age_q[i] <= age_q[i] + AW'(1);
        end
      end
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_sel_o   = out_sel_q;
  assign bus.out_idx_o   = out_idx_q;
endmodule

// File: tb/tb_completion_arbiter.sv
// Bench for completion_arbiter: reference model predicts grants, queued results are compared on output.
module tb_completion_arbiter;
  localparam int N  = 7;
  localparam int W  = 32;
  localparam int SL = 8;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  completion_arbiter_if #(.N(N), .W(W)) bus ();
  completion_arbiter #(.N(N), .W(W), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] vld, hold_mode, acc_q;
  logic [W-1:0] dat [N];
  logic         ready, flush;
  exp_t         exp_q [$];

  int           m_age  [N];
  int           m_wait [N];
  logic         m_valid;
  int           m_idx;
  logic [W-1:0] m_data;
  logic         pend;

  logic tp;
  int   tp_cycles, tp_vld, tp_oh, max_wait, waited;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid_i = vld;
    bus.out_ready_i = ready;
    bus.flush_i     = flush;
    for (int i = 0; i < N; i++) bus.req_data_i[i*W +: W] = dat[i];
  endtask

  // Requesters drop valid once accepted, or present fresh data in hold mode.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_q[i]) begin
        if (hold_mode[i]) dat[i] = $urandom();
        else vld[i] = 1'b0;
      end
    end
    apply();
  endtask

  always @(negedge clk) begin
    logic [N-1:0] g;
    logic [N-1:0] one;
    logic         ok;
    int           pick;
    if (reset) begin
      check("rst_out_valid", bus.out_valid_o, 0);
      check("rst_out_data", bus.out_data_o, 0);
      check("rst_out_sel", bus.out_sel_o, 0);
      check("rst_out_idx", bus.out_idx_o, 0);
      check("rst_req_ready", bus.req_ready_o, 0);
      for (int i = 0; i < N; i++) begin
        m_age[i]  = 0;
        m_wait[i] = 0;
      end
      m_valid = 1'b0;
      m_idx   = 0;
      m_data  = '0;
      pend    = 1'b0;
      acc_q   = '0;
      exp_q.delete();
    end else begin
      if (pend) begin
        exp_t e;
        e      = exp_q.pop_front();
        m_idx  = e.idx;
        m_data = e.data;
        pend   = 1'b0;
      end
      one = '0;
      if (m_valid) one[m_idx] = 1'b1;
      check("out_valid", bus.out_valid_o, m_valid);
      check("out_sel", bus.out_sel_o, one);
      check("out_idx", bus.out_idx_o, m_idx);
      check("out_data", bus.out_data_o, m_data);

      ok   = (!m_valid || ready) && !flush;
      pick = -1;
      if (ok) begin
        for (int i = 0; i < N; i++) if (pick < 0 && vld[i] && m_age[i] == SL) pick = i;
        for (int i = 0; i < N; i++) if (pick < 0 && vld[i]) pick = i;
      end
      g = '0;
      if (pick >= 0) g[pick] = 1'b1;
      check("req_ready", bus.req_ready_o, g);
      acc_q = vld & bus.req_ready_o;

      if (tp) begin
        tp_cycles++;
        if (bus.out_valid_o) tp_vld++;
        if ($onehot(bus.req_ready_o)) tp_oh++;
      end
      for (int i = 0; i < N; i++) begin
        if (vld[i] && !g[i]) m_wait[i]++;
        else begin
          if (tp && g[i] && m_wait[i] > max_wait) max_wait = m_wait[i];
          m_wait[i] = 0;
        end
      end

      if (flush) begin
        m_valid = 1'b0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
      end else begin
        if (pick >= 0) begin
          exp_q.push_back('{pick, dat[pick]});
          pend    = 1'b1;
          m_valid = 1'b1;
        end else if (m_valid && ready) begin
          m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (!vld[i] || g[i]) m_age[i] = 0;
          else if (m_age[i] < SL) m_age[i]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    vld = '0; hold_mode = '0; ready = 1'b1; flush = 1'b0;
    tp = 1'b0; tp_cycles = 0; tp_vld = 0; tp_oh = 0; max_wait = 0; waited = 0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    apply();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Two competitors drain in priority order back to back.
    dat[1] = 32'h11; dat[4] = 32'h44; vld = 7'b0010010; apply();
    #1 check("a_c0_grant", bus.req_ready_o, 7'b0000010);
    step(); #1;
    check("a_c1_idx", bus.out_idx_o, 1);
    check("a_c1_data", bus.out_data_o, 32'h11);
    check("a_c1_grant", bus.req_ready_o, 7'b0010000);
    step(); #1;
    check("a_c2_idx", bus.out_idx_o, 4);
    check("a_c2_data", bus.out_data_o, 32'h44);
    check("a_c2_grant", bus.req_ready_o, 7'b0000000);

    // Downstream stall holds everything for three cycles.
    ready = 1'b0; vld[2] = 1'b1; dat[2] = 32'h22; apply();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("b_hold_grant", bus.req_ready_o, 0);
      check("b_hold_idx", bus.out_idx_o, 4);
      check("b_hold_valid", bus.out_valid_o, 1);
      step();
    end
    ready = 1'b1; apply();
    #1 check("b_release_grant", bus.req_ready_o, 7'b0000100);
    step(); #1;
    check("b_idx", bus.out_idx_o, 2);
    check("b_data", bus.out_data_o, 32'h22);

    // Unit 6 starves behind a permanently valid unit 0.
    hold_mode[0] = 1'b1; dat[0] = $urandom(); dat[6] = 32'h66;
    vld[0] = 1'b1; vld[6] = 1'b1; apply();
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (bus.req_ready_o[6]) begin
        waited = k;
        break;
      end
      step();
    end
    check("c_starve_cycle", waited, 9);
    step();
    hold_mode[0] = 1'b0; vld[0] = 1'b0;

    // Flush with a full output register and a pending request.
    vld[3] = 1'b1; dat[3] = 32'h33; flush = 1'b1; apply();
    #1;
    check("d_pre_valid", bus.out_valid_o, 1);
    check("d_pre_data", bus.out_data_o, 32'h66);
    check("d_flush_grant", bus.req_ready_o, 0);
    step();
    flush = 1'b0; apply();
    #1;
    check("d_valid", bus.out_valid_o, 0);
    check("d_sel", bus.out_sel_o, 0);
    check("d_grant", bus.req_ready_o, 7'b0001000);

    // Asynchronous reset between edges with a held result.
    step();
    ready = 1'b0; apply();
    #1 check("e_pre_valid", bus.out_valid_o, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("e_valid", bus.out_valid_o, 0);
    check("e_data", bus.out_data_o, 0);
    check("e_sel", bus.out_sel_o, 0);
    check("e_idx", bus.out_idx_o, 0);
    check("e_grant", bus.req_ready_o, 0);
    vld = '0; ready = 1'b1; apply();
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // First arbitration after reset is plain priority.
    dat[2] = 32'h202; dat[5] = 32'h505; vld = 7'b0100100; apply();
    #1 check("f_grant", bus.req_ready_o, 7'b0000100);
    step(); step(); step();

    // Saturated throughput with every unit valid.
    hold_mode = '1; vld = '1;
    for (int i = 0; i < N; i++) dat[i] = $urandom();
    apply();
    step();
    tp = 1'b1;
    repeat (150) step();
    tp = 1'b0;
    hold_mode = '0; vld = '0; apply();
    check("g_cycles", tp_cycles, 150);
    check("g_valid_every_cycle", tp_vld, tp_cycles);
    check("g_onehot_every_cycle", tp_oh, tp_cycles);
    check("g_max_wait_bounded", max_wait <= SL + N, 1);

    // Random traffic with stalls and flushes.
    repeat (300) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) begin
          vld[i] = 1'b1;
          dat[i] = $urandom();
        end
      end
      ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      apply();
    end
    flush = 1'b0; ready = 1'b1; vld = '0; apply();
    repeat (3) step();
    check("end_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
